// File: rtl/dac_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// dac_sweep_ctrl_if : packed two-channel DAC stream (tdata/tvalid)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dac_sweep_ctrl_if #(
  parameter int AXIS_TDATA_WIDTH = 32
) ();

  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;

  modport master (
    output tdata,
    output tvalid
  );

  modport slave (
    input tdata,
    input tvalid
  );

endinterface

`default_nettype wire

// File: rtl/dac_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dac_sweep_ctrl : triangle-ramp sweep sequencer with manual-write arbitration
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dac_sweep_ctrl #(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int DWELL_WIDTH      = 16
) (
  input  wire                      clk,
  input  wire                      rst_ni,
  input  wire                      start_i,
  input  wire                      stop_i,
  input  wire                      ch_sel_i,
  input  wire [DAC_DATA_WIDTH-1:0] lo_i,
  input  wire [DAC_DATA_WIDTH-1:0] hi_i,
  input  wire [DAC_DATA_WIDTH-1:0] step_i,
  input  wire [DWELL_WIDTH-1:0]    dwell_i,
  input  wire [7:0]                cycles_i,
  input  wire                      man_we_i,
  input  wire                      man_sel_i,
  input  wire [DAC_DATA_WIDTH-1:0] man_data_i,
  dac_sweep_ctrl_if.master         dac_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     man_drop_o,
  output logic [7:0]               sweep_cnt_o
);

  localparam int DW  = DAC_DATA_WIDTH;
  localparam int PAD = AXIS_TDATA_WIDTH / 2 - DAC_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 ch_q, ch_d;
  logic [DW-1:0]        lo_q, lo_d;
  logic [DW-1:0]        hi_q, hi_d;
  logic [DW-1:0]        step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [7:0]           cycles_q, cycles_d;
  logic [DW-1:0]        code_q, code_d;
  logic [DWELL_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                 fin_q, fin_d;
  logic [DW-1:0]        dac1_q, dac1_d;
  logic [DW-1:0]        dac2_q, dac2_d;
  logic [7:0]           scnt_q, scnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 drop_q, drop_d;
  logic                 tvalid_q;

  logic                 man_ok;
  logic                 sweep_wr;
  logic                 dwell_end;
  logic [DW:0]          up_sum;
  logic signed [DW:0]   dn_diff;
  logic [7:0]           scnt_inc;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    cycles_d  = cycles_q;
    code_d    = code_q;
    dcnt_d    = dcnt_q;
    fin_d     = fin_q;
    dac1_d    = dac1_q;
    dac2_d    = dac2_q;
    scnt_d    = scnt_q;
    err_d     = err_q;
    sweep_wr  = 1'b0;

    man_ok    = man_we_i && ((state_q == S_IDLE) || (man_sel_i != ch_q));
    drop_d    = man_we_i && !man_ok;
    up_sum    = {1'b0, code_q} + {1'b0, step_q};
    dn_diff   = $signed({1'b0, code_q}) - $signed({1'b0, step_q});
    scnt_inc  = (scnt_q == 8'hFF) ? scnt_q : scnt_q + 8'd1;
    dwell_end = (dcnt_q == dwell_q);

    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          if ((lo_i >= hi_i) || (step_i == '0)) begin
            err_d = 1'b1;
          end else begin
            err_d    = 1'b0;
            ch_d     = ch_sel_i;
            lo_d     = lo_i;
            hi_d     = hi_i;
            step_d   = step_i;
            dwell_d  = dwell_i;
            cycles_d = cycles_i;
            code_d   = lo_i;
            dcnt_d   = '0;
            fin_d    = 1'b0;
            scnt_d   = 8'd0;
            sweep_wr = 1'b1;
            state_d  = S_UP;
          end
        end
      end

      S_UP, S_DOWN: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (!dwell_end) begin
          dcnt_d = dcnt_q + DWELL_WIDTH'(1);
        end else begin
          dcnt_d = '0;
          if (state_q == S_UP) begin
            sweep_wr = 1'b1;
            if (up_sum >= {1'b0, hi_q}) begin
              code_d  = hi_q;
              state_d = S_DOWN;
            end else begin
              code_d = up_sum[DW-1:0];
            end
          end else if (fin_q) begin
            // Final lo has served its dwell.
            state_d = S_DONE;
          end else begin
            sweep_wr = 1'b1;
            if (dn_diff <= $signed({1'b0, lo_q})) begin
              code_d = lo_q;
              scnt_d = scnt_inc;
              // lo is held in UP so the next rising code follows its dwell directly.
              if ((cycles_q != 8'd0) && (scnt_inc == cycles_q)) begin
                fin_d = 1'b1;
              end else begin
                state_d = S_UP;
              end
            end else begin
              code_d = dn_diff[DW-1:0];
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Manual write lands first so a same-cycle sweep start overrides its channel.
    if (man_ok) begin
      if (man_sel_i) dac2_d = man_data_i;
      else           dac1_d = man_data_i;
    end
    if (sweep_wr) begin
      if (ch_d) dac2_d = code_d;
      else      dac1_d = code_d;
    end

    busy_d = (state_d == S_UP) || (state_d == S_DOWN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      ch_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cycles_q <= 8'd0;
      code_q   <= '0;
      dcnt_q   <= '0;
      fin_q    <= 1'b0;
      dac1_q   <= '0;
      dac2_q   <= '0;
      scnt_q   <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cycles_q <= cycles_d;
      code_q   <= code_d;
      dcnt_q   <= dcnt_d;
      fin_q    <= fin_d;
      dac1_q   <= dac1_d;
      dac2_q   <= dac2_d;
      scnt_q   <= scnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      tvalid_q <= 1'b1;
    end
  end

  assign dac_o.tdata  = {{PAD{1'b0}}, dac2_q, {PAD{1'b0}}, dac1_q};
  assign dac_o.tvalid = tvalid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign man_drop_o   = drop_q;
  assign sweep_cnt_o  = scnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dac_sweep_ctrl : scoreboard bench with a plan-based sweep reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
`default_nettype none

module tb_dac_sweep_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0, ch_sel_i = 1'b0;
  logic        man_we_i = 1'b0, man_sel_i = 1'b0;
  logic [13:0] lo_i = '0, hi_i = '0, step_i = '0, man_data_i = '0;
  logic [15:0] dwell_i = '0;
  logic [7:0]  cycles_i = '0;
  logic        busy_o, done_o, err_o, man_drop_o;
  logic [7:0]  sweep_cnt_o;

  dac_sweep_ctrl_if #(.AXIS_TDATA_WIDTH(32)) dac_if ();

  dac_sweep_ctrl #(
    .DAC_DATA_WIDTH(14), .AXIS_TDATA_WIDTH(32), .DWELL_WIDTH(16)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .ch_sel_i(ch_sel_i), .lo_i(lo_i), .hi_i(hi_i), .step_i(step_i),
    .dwell_i(dwell_i), .cycles_i(cycles_i), .man_we_i(man_we_i),
    .man_sel_i(man_sel_i), .man_data_i(man_data_i), .dac_o(dac_if),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .man_drop_o(man_drop_o), .sweep_cnt_o(sweep_cnt_o)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [31:0] tdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        drop;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    logic [13:0] code;
    int          cnt;
  } ent_t;

  exp_t exp_q[$];
  ent_t plan[$];

  int          checks = 0;
  int          failures = 0;
  int          mode = M_IDLE;
  logic [13:0] m_dac [2];
  logic        m_err = 1'b0;
  logic [7:0]  m_cnt = 8'd0;
  logic        m_ch = 1'b0;
  int          m_lo, m_hi, m_step, m_dwell, m_cycles, periods_built;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every code of a triangle period, each repeated dwell+1 times, tagged with
  // the completed-period count visible while it is on the DAC.
  function void push_code(int code, int cnt);
    ent_t en;
    en.code = 14'(code);
    en.cnt  = cnt;
    for (int r = 0; r <= m_dwell; r++) plan.push_back(en);
  endfunction

  function void add_period(bit first);
    int c, prev, k;
    bit turned;
    periods_built++;
    prev = (periods_built - 1 > 255) ? 255 : periods_built - 1;
    k    = (periods_built > 255) ? 255 : periods_built;
    c = m_lo;
    if (first) push_code(c, prev);
    turned = 1'b0;
    while (!turned) begin
      c = c + m_step;
      if (c >= m_hi) begin c = m_hi; turned = 1'b1; end
      push_code(c, prev);
    end
    turned = 1'b0;
    while (!turned) begin
      c = c - m_step;
      if (c <= m_lo) begin push_code(m_lo, k); turned = 1'b1; end
      else push_code(c, prev);
    end
  endfunction

  function void model_reset();
    mode = M_IDLE; m_dac[0] = '0; m_dac[1] = '0;
    m_err = 1'b0; m_cnt = 8'd0; m_ch = 1'b0;
    plan.delete();
  endfunction

  function void model_step();
    exp_t e;
    ent_t en;
    bit acc;
    e.drop = 1'b0;
    e.done = 1'b0;
    acc = man_we_i && (mode == M_IDLE || man_sel_i != m_ch);
    if (man_we_i && !acc) e.drop = 1'b1;
    if (acc) m_dac[man_sel_i] = man_data_i;
    case (mode)
      M_IDLE: begin
        if (start_i && !stop_i) begin
          if (lo_i >= hi_i || step_i == 14'd0) begin
            m_err = 1'b1;
          end else begin
            m_err = 1'b0; m_ch = ch_sel_i;
            m_lo = int'(lo_i); m_hi = int'(hi_i); m_step = int'(step_i);
            m_dwell = int'(dwell_i); m_cycles = int'(cycles_i);
            plan.delete(); periods_built = 0;
            add_period(1'b1);
            for (int p = 1; p < m_cycles; p++) add_period(1'b0);
            en = plan.pop_front();
            m_dac[m_ch] = en.code; m_cnt = 8'(en.cnt);
            mode = M_RUN;
          end
        end
      end
      M_RUN: begin
        if (stop_i) begin
          mode = M_IDLE;
        end else begin
          if (plan.size() == 0 && m_cycles == 0) add_period(1'b0);
          if (plan.size() == 0) begin
            mode = M_DONE; e.done = 1'b1;
          end else begin
            en = plan.pop_front();
            m_dac[m_ch] = en.code; m_cnt = 8'(en.cnt);
          end
        end
      end
      default: mode = M_IDLE;
    endcase
    e.busy  = (mode == M_RUN);
    e.err   = m_err;
    e.cnt   = m_cnt;
    e.tdata = {2'b00, m_dac[1], 2'b00, m_dac[0]};
    exp_q.push_back(e);
  endfunction

  // Called at a falling edge: predicts the next rising edge, then waits it out.
  task automatic tick();
    model_step();
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0; man_we_i = 1'b0;
  endtask

  task automatic cfg(input logic ch, input int lo, input int hi, input int st,
                     input int dw, input int cy);
    ch_sel_i = ch; lo_i = 14'(lo); hi_i = 14'(hi); step_i = 14'(st);
    dwell_i = 16'(dw); cycles_i = 8'(cy);
  endtask

  task automatic run_to_idle(input int budget);
    int g;
    g = 0;
    while (mode != M_IDLE && g < budget) begin tick(); g++; end
    if (mode != M_IDLE) begin stop_i = 1'b1; tick(); end
  endtask

  task automatic rst_pulse();
    #0.5 rst_ni = 1'b0;
    #1.5;
    chk("async_rst_tdata", 64'(dac_if.tdata), 64'd0);
    chk("async_rst_busy", 64'(busy_o), 64'd0);
    chk("async_rst_tvalid", 64'(dac_if.tvalid), 64'd0);
    #1.5 rst_ni = 1'b1;
    model_reset();
  endtask

  // Monitor: compares every presented stream beat against the scoreboard.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stream_valid", 64'(dac_if.tvalid), 64'd1);
        a = {dac_if.tdata, busy_o, done_o, err_o, man_drop_o, sweep_cnt_o};
        chk("scoreboard", 64'(a), 64'(e));
      end else if (dac_if.tvalid === 1'b1) begin
        chk("beat_without_expectation", 64'd1, 64'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int basic_seq[7] = '{100, 104, 108, 110, 106, 102, 100};
    int cont_seq[10] = '{0, 8191, 16382, 16383, 8192, 1, 0, 8191, 16382, 16383};
    model_reset();
    #2;
    chk("reset_tdata", 64'(dac_if.tdata), 64'd0);
    chk("reset_tvalid", 64'(dac_if.tvalid), 64'd0);
    chk("reset_flags", 64'({busy_o, done_o, err_o, man_drop_o}), 64'd0);
    chk("reset_cnt", 64'(sweep_cnt_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    chk("tvalid_after_reset", 64'(dac_if.tvalid), 64'd1);

    // Manual writes while idle
    man_we_i = 1'b1; man_sel_i = 1'b0; man_data_i = 14'h0111; tick();
    man_we_i = 1'b1; man_sel_i = 1'b1; man_data_i = 14'h0222; tick();

    // Basic sweep
    cfg(1'b0, 100, 110, 4, 1, 1); start_i = 1'b1; tick();
    for (int i = 0; i < 14; i++) begin
      chk("basic_code", 64'(dac_if.tdata[13:0]), 64'(basic_seq[i / 2]));
      chk("basic_busy", 64'(busy_o), 64'd1);
      tick();
    end
    chk("basic_done", 64'({busy_o, done_o}), 64'b01);
    chk("basic_cnt", 64'(sweep_cnt_o), 64'd1);
    tick();
    chk("basic_done_once", 64'(done_o), 64'd0);

    // Config errors, then a valid start clears the error
    cfg(1'b0, 50, 50, 4, 0, 1); start_i = 1'b1; tick();
    chk("err_lo_eq_hi", 64'({err_o, busy_o}), 64'b10);
    cfg(1'b0, 10, 50, 0, 0, 1); start_i = 1'b1; tick();
    chk("err_step_zero", 64'({err_o, busy_o}), 64'b10);
    cfg(1'b0, 10, 50, 20, 0, 1); start_i = 1'b1; tick();
    chk("err_cleared", 64'({err_o, busy_o}), 64'b01);
    run_to_idle(50);

    // Arbitration during a DAC2 sweep
    cfg(1'b1, 1000, 1400, 50, 2, 1); start_i = 1'b1; tick();
    tick(); tick();
    man_we_i = 1'b1; man_sel_i = 1'b0; man_data_i = 14'h1234; tick();
    chk("arb_dac1", 64'(dac_if.tdata[13:0]), 64'h1234);
    man_we_i = 1'b1; man_sel_i = 1'b1; man_data_i = 14'h0ABC; tick();
    chk("arb_drop", 64'({man_drop_o, busy_o}), 64'b11);
    run_to_idle(200);

    // start+stop together in idle, then start while busy
    cfg(1'b0, 5, 90, 7, 0, 1); start_i = 1'b1; stop_i = 1'b1; tick();
    chk("start_stop_idle", 64'(busy_o), 64'd0);
    cfg(1'b0, 200, 260, 20, 0, 2); start_i = 1'b1; tick();
    tick(); tick();
    cfg(1'b1, 0, 5, 1, 3, 0); start_i = 1'b1; tick();
    run_to_idle(100);

    // Continuous sweep, full-scale limits, aborted by stop
    cfg(1'b0, 0, 16383, 8191, 0, 0); start_i = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      chk("cont_code", 64'(dac_if.tdata[13:0]), 64'(cont_seq[i]));
      if (i == 9) stop_i = 1'b1;
      tick();
    end
    chk("cont_stopped", 64'(busy_o), 64'd0);
    tick(); tick();
    chk("cont_frozen", 64'(dac_if.tdata[13:0]), 64'd16383);

    // Asynchronous reset while ramping down
    cfg(1'b0, 100, 110, 4, 1, 1); start_i = 1'b1; tick();
    for (int i = 0; i < 9; i++) tick();
    rst_pulse();
    tick();
    chk("tvalid_after_async", 64'(dac_if.tvalid), 64'd1);

    // Randomised episodes
    for (int ep = 0; ep < 40; ep++) begin
      int lo, span, st, g;
      lo   = int'($urandom_range(0, 16000));
      span = int'($urandom_range(1, 383));
      st   = int'($urandom_range(span / 16 + 1, span + 20));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) span = 0; else st = 0;
      end
      cfg(1'($urandom_range(0, 1)), lo, lo + span, st,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      start_i = 1'b1;
      man_we_i = ($urandom_range(0, 3) == 0);
      man_sel_i = 1'($urandom_range(0, 1));
      man_data_i = 14'($urandom_range(0, 16383));
      tick();
      g = 0;
      while (mode != M_IDLE && g < 600) begin
        man_we_i = ($urandom_range(0, 3) == 0);
        man_sel_i = 1'($urandom_range(0, 1));
        man_data_i = 14'($urandom_range(0, 16383));
        stop_i = ($urandom_range(0, 79) == 0);
        start_i = ($urandom_range(0, 24) == 0);
        lo_i = 14'($urandom_range(0, 16383));
        hi_i = 14'($urandom_range(0, 16383));
        step_i = 14'($urandom_range(0, 16383));
        ch_sel_i = 1'($urandom_range(0, 1));
        tick();
        g++;
      end
      if (mode != M_IDLE) begin stop_i = 1'b1; tick(); end
      for (int j = 0; j < 2; j++) begin
        man_we_i = 1'b1;
        man_sel_i = 1'($urandom_range(0, 1));
        man_data_i = 14'($urandom_range(0, 16383));
        tick();
      end
    end

    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
